proximity_alert: RTL and testbench

//   Consumes the averaged 15-bit echo width from the ultrasonic ranging stage and turns it into a debounced proximity zone.

---
 rtl/proximity_alert.sv | 90 +++++++++
 tb/tb_proximity_alert.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/proximity_alert.sv
// proximity_alert: debounced, hysteretic proximity zone from echo width, driving a zone-dependent beep pattern.
module proximity_alert #(
  parameter int SAMPLE_DIV  = 1000,
  parameter int CRIT_TH     = 600,
  parameter int NEAR_TH     = 1500,
  parameter int MID_TH      = 3000,
  parameter int HYST        = 100,
  parameter int DEBOUNCE    = 3,
  parameter int BEEP_ON     = 2000,
  parameter int MID_PERIOD  = 20000,
  parameter int NEAR_PERIOD = 8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] pulse,
  output logic [1:0]  zone,
  output logic        alert,
  output logic        buzz
);
  localparam int SW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int BW = $clog2((MID_PERIOD > NEAR_PERIOD ? MID_PERIOD : NEAR_PERIOD) + 1);
  localparam logic [SW-1:0] SMAX = SW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE);
  localparam logic [BW-1:0] ON = BW'(BEEP_ON);
  localparam logic [BW-1:0] MID_LAST = BW'(MID_PERIOD - 1);
  localparam logic [BW-1:0] NEAR_LAST = BW'(NEAR_PERIOD - 1);
  localparam logic [15:0] CRIT_L = 16'(CRIT_TH);
  localparam logic [15:0] NEAR_L = 16'(NEAR_TH);
  localparam logic [15:0] MID_L = 16'(MID_TH);
  localparam logic [15:0] CRIT_OUT = 16'(CRIT_TH + HYST);
  localparam logic [15:0] NEAR_OUT = 16'(NEAR_TH + HYST);
  localparam logic [15:0] MID_OUT = 16'(MID_TH + HYST);
  localparam logic [1:0] FAR = 2'd0, MID = 2'd1, NEAR = 2'd2, CRIT = 2'd3;
  localparam logic [1:0] IDLE = 2'd0, PATTERN = 2'd1, SOLID = 2'd2;

  logic [SW-1:0] smp_q, smp_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [BW-1:0] beep_q, beep_d, beep_last;
  logic [1:0]    zone_q, zone_d, last_q, last_d, raw, cand, state;
  logic [15:0]   p16, lvl;
  logic          alert_q, alert_d, buzz_q, buzz_d, tick;

  always_comb begin
    tick = smp_q == SMAX;
    smp_d = tick ? '0 : smp_q + 1'b1;
    p16 = {1'b0, pulse};
    raw = p16 < CRIT_L ? CRIT : p16 < NEAR_L ? NEAR : p16 < MID_L ? MID : FAR;
    lvl = zone_q == CRIT ? CRIT_OUT : zone_q == NEAR ? NEAR_OUT : MID_OUT;
    // an outward move must clear the exit level of the current zone, else it counts as staying put
    cand = (raw < zone_q && p16 < lvl) ? zone_q : raw;
    cnt_nxt = (cand == last_q) ? cnt_q + 1'b1 : DW'(1);
    zone_d = zone_q;
    cnt_d = cnt_q;
    last_d = last_q;
    if (tick && pulse != '0) begin
      last_d = (cand == zone_q) ? last_q : cand;
      cnt_d = (cand == zone_q || cnt_nxt >= DMAX) ? '0 : cnt_nxt;
      zone_d = (cand != zone_q && cnt_nxt >= DMAX) ? cand : zone_q;
    end
    state = zone_q == FAR ? IDLE : zone_q == CRIT ? SOLID : PATTERN;
    beep_last = zone_q == MID ? MID_LAST : NEAR_LAST;
    beep_d = (zone_d != zone_q || state != PATTERN || beep_q == beep_last) ? '0 : beep_q + 1'b1;
    buzz_d = state == SOLID || (state == PATTERN && beep_q < ON);
    alert_d = zone_d != FAR;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      smp_q <= '0;
      cnt_q <= '0;
      last_q <= FAR;
      zone_q <= FAR;
      beep_q <= '0;
      alert_q <= 1'b0;
      buzz_q <= 1'b0;
    end else begin
      smp_q <= smp_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      zone_q <= zone_d;
      beep_q <= beep_d;
      alert_q <= alert_d;
      buzz_q <= buzz_d;
    end

  assign zone = zone_q;
  assign alert = alert_q;
  assign buzz = buzz_q;
endmodule

// File: tb/tb_proximity_alert.sv
// tb_proximity_alert: randomized and directed stimulus checked every cycle against a behavioural zone/beep model.
module tb_proximity_alert;
  logic        clk, rst_n;
  logic [14:0] pulse;
  logic [1:0]  zone;
  logic        alert, buzz;
  int checks = 0, errors = 0, hi = 0;
  int m_zone, m_last, m_cnt, m_age, m_cyc, m_c, m_nz, m_per;
  bit m_buzz, m_nb;

  proximity_alert #(.SAMPLE_DIV(4), .DEBOUNCE(3), .BEEP_ON(2), .MID_PERIOD(8), .NEAR_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .zone(zone), .alert(alert), .buzz(buzz));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int raw_zone(int p);
    return p < 600 ? 3 : p < 1500 ? 2 : p < 3000 ? 1 : 0;
  endfunction

  function automatic int exit_level(int z);
    return z == 3 ? 700 : z == 2 ? 1600 : 3100;
  endfunction

  // Model: samples every 4th cycle; beep phase is the number of cycles since the zone last changed.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_zone = 0; m_last = 0; m_cnt = 0; m_age = 0; m_cyc = 0; m_buzz = 0;
    end else begin
      m_per = (m_zone == 1) ? 8 : 4;
      m_nb = (m_zone == 3) || ((m_zone == 1 || m_zone == 2) && (m_age % m_per) < 2);
      m_nz = m_zone;
      if (m_cyc % 4 == 3 && pulse != 0) begin
        m_c = raw_zone(int'(pulse));
        if (m_c < m_zone && int'(pulse) < exit_level(m_zone)) m_c = m_zone;
        if (m_c == m_zone) m_cnt = 0;
        else begin
          if (m_c == m_last) m_cnt++;
          else begin m_cnt = 1; m_last = m_c; end
          if (m_cnt >= 3) begin m_nz = m_c; m_cnt = 0; end
        end
      end
      m_age = (m_nz != m_zone) ? 0 : m_age + 1;
      m_zone = m_nz;
      m_buzz = m_nb;
      m_cyc++;
    end

  task automatic chk(string nm, int act, int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("zone", int'(zone), m_zone);
        chk("alert", int'(alert), int'(m_zone != 0));
        chk("buzz", int'(buzz), int'(m_buzz));
        hi += int'(buzz);
      end
      @(negedge clk);
    end
  endtask

  task automatic tick_pulse(int p, int ticks);
    pulse = 15'(p);
    run(4 * ticks);
  endtask

  initial begin
    rst_n = 1; pulse = 0;
    #3 rst_n = 0;
    #1;
    chk("reset_zone", int'(zone), 0);
    chk("reset_alert", int'(alert), 0);
    chk("reset_buzz", int'(buzz), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    pulse = 4000; hi = 0;
    run(100);
    chk("far_zone", int'(zone), 0);
    chk("far_buzz_count", hi, 0);
    pulse = 1000;
    run(8);
    chk("near_two_ticks", int'(zone), 0);
    run(4);
    chk("near_three_ticks", int'(zone), 2);
    run(4); hi = 0;
    run(8);
    chk("near_buzz_count", hi, 4);
    tick_pulse(1550, 10);
    chk("hyst_hold", int'(zone), 2);
    tick_pulse(1700, 3);
    chk("mid_zone", int'(zone), 1);
    run(4); hi = 0;
    run(16);
    chk("mid_buzz_count", hi, 4);
    for (int i = 0; i < 10; i++) tick_pulse((i % 2) ? 4000 : 500, 1);
    chk("alternate_hold", int'(zone), 1);
    tick_pulse(300, 4);
    chk("crit_zone", int'(zone), 3);
    tick_pulse(0, 5);
    chk("zero_hold_zone", int'(zone), 3);
    chk("zero_hold_buzz", int'(buzz), 1);
    rst_n = 0;
    #1;
    chk("async_zone", int'(zone), 0);
    chk("async_buzz", int'(buzz), 0);
    chk("async_alert", int'(alert), 0);
    @(negedge clk);
    rst_n = 1;
    pulse = 100;
    run(8);
    chk("jump_two_ticks", int'(zone), 0);
    run(4);
    chk("jump_crit", int'(zone), 3);
    run(1);
    chk("jump_buzz", int'(buzz), 1);
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 5))
        0: pulse = 0;
        1: pulse = 15'($urandom_range(550, 750));
        2: pulse = 15'($urandom_range(1450, 1650));
        3: pulse = 15'($urandom_range(2950, 3150));
        default: pulse = 15'($urandom_range(1, 32767));
      endcase
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 0;
        #1 chk("rand_reset_zone", int'(zone), 0);
        @(negedge clk);
        rst_n = 1;
      end
      run($urandom_range(1, 20));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
